bus_grant_ctrl: RTL and testbench
=================================

Name: bus_grant_ctrl

Overview:
- Replacement bus-ownership controller for the 4-master / 8-slave shared bus.
- Grants the shared bus to one of m0..m3 using rotating (round-robin) priority.
- Holds the grant for the whole of a transfer, from s_as_ low until m_rdy_ low.
- Watchdog: aborts a transfer that gets no ready within TIMEOUT cycles, pulses an error and revokes the grant.
- Its grnt_ outputs drive the existing master mux directly.

Parameters:
- TIMEOUT, 16, cycles in XFER without m_rdy_ before abort; legal range 2..255.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- m0_req_..m3_req_  in  1 each  bus request, active-low
- s_as_  in  1  muxed address strobe of current owner, active-low
- m_rdy_  in  1  muxed slave ready, active-low
- m0_grnt_..m3_grnt_  out  1 each  bus grant, active-low, registered, one-hot-low or all high
- owner  out  2  index of current grantee; valid while busy=1
- busy  out  1  a grant is currently held
- bus_err  out  1  one-cycle pulse on watchdog abort
- err_mst  out  2  index of aborted master; holds until next abort

Behaviour:
- Reset (reset=0, asynchronous):
  - all grnt_=1, busy=0, owner=0, bus_err=0, err_mst=0.
  - state=IDLE, watchdog counter=0, rr pointer last=3, so m0 has top priority after reset.
  - Reset mid-transfer revokes the grant immediately. No error is flagged.
- States: IDLE, OWN, XFER, ERR.
- Round-robin pick: search order starts at last+1 mod 4 and wraps around. last updates to the winner on every grant.
- IDLE:
  - If any req_=0 at a rising edge: grant the picked master at that edge, go to OWN.
  - Latency from req_ sampled low to grnt_ low is 1 edge.
- OWN:
  - s_as_=0 → XFER, counter cleared to 0.
  - Owner req_=1 and s_as_=1 → release at that edge.
    - Another req_ pending: hand off directly in the same edge. The picker excludes the current owner. Stay in OWN with zero dead cycles.
    - No other req_ pending: all grnt_=1, go to IDLE.
  - Requests from other masters are ignored while the owner keeps req_ low. There is no preemption.
- XFER:
  - Counter increments each cycle.
  - m_rdy_=0 → OWN, counter cleared.
  - Owner dropping req_ during XFER does not release the grant. Release is evaluated in OWN after the transfer completes.
  - m_rdy_=1 and counter==TIMEOUT-1 → bus_err=1 for one cycle, err_mst=owner, all grnt_=1, go to ERR.
  - m_rdy_=0 in the same cycle as the timeout: ready wins, no error.
- ERR:
  - Exactly one cycle with all grants high, then IDLE.
  - last stays at the aborted master, so it moves to lowest priority.
- Invariants:
  - At most one grnt_ is low.
  - busy = (any grnt_ low).
  - owner is stable while busy.
- Width rules:
  - Counter saturates; it never wraps.
  - Pointer arithmetic is 2-bit mod-4.

Decomposition:
- Shared package bus_pkg:
  - state encoding constants IDLE/OWN/XFER/ERR.
  - NUM_MST=4, MST_IDX_W=2.
  - active-low level constants ENABLE_=1'b0 and DISABLE_=1'b1.
- One sub-module: bus_rr_pick.
  - Combinational rotating priority encoder.
  - Inputs: 4-bit active-high request vector, 2-bit last, 1-bit exclude-last flag.
  - Outputs: 2-bit winner, valid.

Test Plan:
- Reset, then m0_req_=0 and m2_req_=0 at the same edge → m0_grnt_=0 one edge later, owner=0, busy=1. Release m0 → m2 granted at the same edge with no idle cycle.
- All four req_ held low, each owner drops req_ after one transfer → grant order 0,1,2,3,0. Never two grnt_ low at once.
- Owner asserts s_as_=0 and drops req_ one cycle later; m_rdy_=0 after 5 cycles → grant held through XFER; released in the OWN cycle after ready.
- m1 in XFER, m_rdy_ held 1, TIMEOUT=16 → bus_err=1 for exactly one cycle on the 16th XFER cycle, err_mst=1. All grnt_ high for the ERR cycle, then m2 is preferred over m1.
- m_rdy_=0 exactly on counter==TIMEOUT-1 → no bus_err; state returns to OWN.
- reset pulled low mid-XFER asynchronously, between clock edges → all grnt_=1, busy=0, bus_err=0 immediately. After reset release, m0 wins a 4-way tie.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants for the 4-master bus ownership controller: state encoding,
// master index sizing and active-low level names.
package bus_pkg;

  localparam int NUM_MST   = 4;
  localparam int MST_IDX_W = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Active-low one-hot grant vector for a single master.
  function automatic logic [NUM_MST-1:0] grant_vec(input logic [MST_IDX_W-1:0] idx);
    logic [NUM_MST-1:0] g;
    g      = {NUM_MST{DISABLE_}};
    g[idx] = ENABLE_;
    return g;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotating-priority encoder: highest priority at last+1, lowest
// at last itself, which can be masked out for owner-excluding hand-offs.
module bus_rr_pick
  import bus_pkg::*;
(
  input  logic [NUM_MST-1:0]   req,
  input  logic [MST_IDX_W-1:0] last,
  input  logic                 excl_last,
  output logic [MST_IDX_W-1:0] winner,
  output logic                 valid
);

  logic [MST_IDX_W-1:0] cand [NUM_MST];
  logic [NUM_MST-1:0]   elig;

  // cand[gi] is the master at rotation distance gi+1 from last.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MST; gi++) begin : g_rot
      assign cand[gi] = last + MST_IDX_W'(gi + 1);
      if (gi == NUM_MST - 1) begin : g_self
        assign elig[gi] = req[cand[gi]] & ~excl_last;
      end else begin : g_other
        assign elig[gi] = req[cand[gi]];
      end
    end
  endgenerate

  // Walk from lowest to highest priority so the nearest eligible master wins.
  always_comb begin
    winner = last;
    valid  = 1'b0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = cand[i];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Round-robin bus ownership controller for four masters with a transfer
// watchdog; grants are registered and drive the master mux directly.
module bus_grant_ctrl
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       s_as_,
  input  logic       m_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy,
  output logic       bus_err,
  output logic [1:0] err_mst
);

  logic [1:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [MST_IDX_W-1:0] last_reg, last_next;
  logic [MST_IDX_W-1:0] owner_reg, owner_next;
  logic [MST_IDX_W-1:0] err_mst_reg, err_mst_next;
  logic [NUM_MST-1:0]   grnt_reg, grnt_next;
  logic                 bus_err_reg, bus_err_next;

  logic [NUM_MST-1:0]   req_vec;
  logic [MST_IDX_W-1:0] pick_idx;
  logic                 pick_valid;
  logic                 owner_req;
  logic                 timeout_hit;
  logic [CNT_W-1:0]     cnt_inc;

  assign req_vec     = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req   = req_vec[owner_reg];
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign cnt_inc     = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

  // In OWN the only use of the picker is a hand-off, so the owner is masked.
  bus_rr_pick u_pick (
    .req       (req_vec),
    .last      (last_reg),
    .excl_last (state_reg == OWN),
    .winner    (pick_idx),
    .valid     (pick_valid)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    last_next    = last_reg;
    owner_next   = owner_reg;
    grnt_next    = grnt_reg;
    bus_err_next = 1'b0;
    err_mst_next = err_mst_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grnt_next  = grant_vec(pick_idx);
          owner_next = pick_idx;
          last_next  = pick_idx;
          state_next = OWN;
        end
      end
      OWN: begin
        if (s_as_ == ENABLE_) begin
          state_next = XFER;
          cnt_next   = '0;
        end else if (!owner_req) begin
          if (pick_valid) begin
            grnt_next  = grant_vec(pick_idx);
            owner_next = pick_idx;
            last_next  = pick_idx;
          end else begin
            grnt_next  = {NUM_MST{DISABLE_}};
            state_next = IDLE;
          end
        end
      end
      XFER: begin
        cnt_next = cnt_inc;
        if (m_rdy_ == ENABLE_) begin
          state_next = OWN;
          cnt_next   = '0;
        end else if (timeout_hit) begin
          bus_err_next = 1'b1;
          err_mst_next = owner_reg;
          grnt_next    = {NUM_MST{DISABLE_}};
          cnt_next     = '0;
          state_next   = ERR;
        end
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        grnt_next  = {NUM_MST{DISABLE_}};
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      last_reg    <= MST_IDX_W'(NUM_MST - 1);
      owner_reg   <= '0;
      grnt_reg    <= {NUM_MST{DISABLE_}};
      bus_err_reg <= 1'b0;
      err_mst_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      last_reg    <= last_next;
      owner_reg   <= owner_next;
      grnt_reg    <= grnt_next;
      bus_err_reg <= bus_err_next;
      err_mst_reg <= err_mst_next;
    end
  end

  assign m0_grnt_ = grnt_reg[0];
  assign m1_grnt_ = grnt_reg[1];
  assign m2_grnt_ = grnt_reg[2];
  assign m3_grnt_ = grnt_reg[3];
  assign owner    = owner_reg;
  assign busy     = ~&grnt_reg;
  assign bus_err  = bus_err_reg;
  assign err_mst  = err_mst_reg;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Directed bench for bus_grant_ctrl: a vector table for arbitration and
// hand-off, plus hand-written watchdog and asynchronous reset sequences.
module tb_bus_grant_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_;
  logic       s_as_;
  logic       m_rdy_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       busy;
  logic       bus_err;
  logic [1:0] err_mst;
  logic [3:0] grnt_;

  int checks = 0;
  int errors = 0;

  assign grnt_ = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  bus_grant_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (req_[0]),
    .m1_req_  (req_[1]),
    .m2_req_  (req_[2]),
    .m3_req_  (req_[3]),
    .s_as_    (s_as_),
    .m_rdy_   (m_rdy_),
    .m0_grnt_ (m0_grnt_),
    .m1_grnt_ (m1_grnt_),
    .m2_grnt_ (m2_grnt_),
    .m3_grnt_ (m3_grnt_),
    .owner    (owner),
    .busy     (busy),
    .bus_err  (bus_err),
    .err_mst  (err_mst)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] req_;
    logic       s_as_;
    logic       m_rdy_;
    logic [3:0] exp_grnt_;
    logic [1:0] exp_owner;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_onehot(input string name);
    int lows;
    lows = 0;
    for (int i = 0; i < 4; i++) if (grnt_[i] == 1'b0) lows++;
    check({name, ".onehot"}, (lows <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    //          name        req_     as  rdy  grnt_    own  busy err
    vecs[0]  = '{"m0m2_tie",  4'b1010, 1, 1, 4'b1110, 2'd0, 1, 0};
    vecs[1]  = '{"handoff2",  4'b1011, 1, 1, 4'b1011, 2'd2, 1, 0};
    vecs[2]  = '{"xfer_in",   4'b1011, 0, 1, 4'b1011, 2'd2, 1, 0};
    vecs[3]  = '{"drop_xfer", 4'b1111, 1, 1, 4'b1011, 2'd2, 1, 0};
    vecs[4]  = '{"ready",     4'b1111, 1, 0, 4'b1011, 2'd2, 1, 0};
    vecs[5]  = '{"rel_idle",  4'b1111, 1, 1, 4'b1111, 2'd2, 0, 0};
    vecs[6]  = '{"all_req3",  4'b0000, 1, 1, 4'b0111, 2'd3, 1, 0};
    vecs[7]  = '{"rr_to0",    4'b1000, 1, 1, 4'b1110, 2'd0, 1, 0};
    vecs[8]  = '{"rr_to1",    4'b0001, 1, 1, 4'b1101, 2'd1, 1, 0};
    vecs[9]  = '{"rr_to2",    4'b0010, 1, 1, 4'b1011, 2'd2, 1, 0};
    vecs[10] = '{"rr_to3",    4'b0100, 1, 1, 4'b0111, 2'd3, 1, 0};
    vecs[11] = '{"rel_idle2", 4'b1111, 1, 1, 4'b1111, 2'd3, 0, 0};
    vecs[12] = '{"grant0",    4'b1110, 1, 1, 4'b1110, 2'd0, 1, 0};
    vecs[13] = '{"no_preempt",4'b0000, 1, 1, 4'b1110, 2'd0, 1, 0};
    vecs[14] = '{"rel_idle3", 4'b1111, 1, 1, 4'b1111, 2'd0, 0, 0};

    reset  = 1'b0;
    req_   = 4'b1111;
    s_as_  = 1'b1;
    m_rdy_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.grnt", {28'd0, grnt_}, 32'hF);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.owner", {30'd0, owner}, 32'd0);
    check("rst.bus_err", {31'd0, bus_err}, 32'd0);
    check("rst.err_mst", {30'd0, err_mst}, 32'd0);
    reset = 1'b1;

    foreach (vecs[k]) begin
      req_   = vecs[k].req_;
      s_as_  = vecs[k].s_as_;
      m_rdy_ = vecs[k].m_rdy_;
      step();
      check({vecs[k].name, ".grnt"}, {28'd0, grnt_}, {28'd0, vecs[k].exp_grnt_});
      check({vecs[k].name, ".busy"}, {31'd0, busy}, {31'd0, vecs[k].exp_busy});
      check({vecs[k].name, ".bus_err"}, {31'd0, bus_err}, {31'd0, vecs[k].exp_err});
      if (vecs[k].exp_busy)
        check({vecs[k].name, ".owner"}, {30'd0, owner}, {30'd0, vecs[k].exp_owner});
      check_onehot(vecs[k].name);
    end

    // Watchdog abort of m1, then m2 preferred over m1.
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    req_ = 4'b1001;
    s_as_ = 1'b1;
    m_rdy_ = 1'b1;
    step();
    check("to.grant_m1", {28'd0, grnt_}, 32'b1101);
    s_as_ = 1'b0;
    step();
    s_as_ = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("to.xfer%0d.err", i), {31'd0, bus_err}, 32'd0);
      check($sformatf("to.xfer%0d.grnt", i), {28'd0, grnt_}, 32'b1101);
    end
    step();
    check("to.bus_err", {31'd0, bus_err}, 32'd1);
    check("to.err_mst", {30'd0, err_mst}, 32'd1);
    check("to.err_grnt", {28'd0, grnt_}, 32'hF);
    check("to.err_busy", {31'd0, busy}, 32'd0);
    step();
    check("to.err_pulse_end", {31'd0, bus_err}, 32'd0);
    check("to.idle_grnt", {28'd0, grnt_}, 32'hF);
    check("to.err_mst_hold", {30'd0, err_mst}, 32'd1);
    step();
    check("to.m2_preferred", {28'd0, grnt_}, 32'b1011);
    check("to.owner2", {30'd0, owner}, 32'd2);

    // Ready arriving exactly on the last watchdog cycle wins.
    s_as_ = 1'b0;
    step();
    s_as_ = 1'b1;
    for (int i = 1; i <= 15; i++) step();
    m_rdy_ = 1'b0;
    step();
    check("edge.no_err", {31'd0, bus_err}, 32'd0);
    check("edge.grnt", {28'd0, grnt_}, 32'b1011);
    m_rdy_ = 1'b1;
    step();
    check("edge.own_no_err", {31'd0, bus_err}, 32'd0);
    check("edge.own_grnt", {28'd0, grnt_}, 32'b1011);

    // Asynchronous reset mid-transfer.
    s_as_ = 1'b0;
    step();
    s_as_ = 1'b1;
    step();
    #3 reset = 1'b0;
    #1;
    check("arst.grnt", {28'd0, grnt_}, 32'hF);
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.bus_err", {31'd0, bus_err}, 32'd0);
    #2 reset = 1'b1;
    req_ = 4'b0000;
    step();
    check("arst.tie_m0", {28'd0, grnt_}, 32'b1110);
    check("arst.owner0", {30'd0, owner}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
